imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_assembler.sv | 51 +++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : loader_pkg
//  Purpose : Shared types and constants for the instruction-memory loader.
//            Holds the loader FSM state encoding and the byte/word ratio.
//  Config  : LOADER_CHECKSUM_EN adds the CSUM state to the encoding.
//  Rev     : 1.0  initial release
// ============================================================================
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    DONE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ERR  = 3'd3,
    CSUM = 3'd4
`else
    ERR  = 3'd3
`endif
  } state_e;

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : byte_assembler
//  Purpose : Packs a little-endian byte stream into 32-bit words.
//  Ports   : clk_i / rst_i  - clock, synchronous active-high reset
//            en_i           - a byte is being consumed this cycle
//            data_i         - the byte
//            word_valid_o   - high in the cycle the 4th byte of a word is consumed
//            word_o         - assembled word including the current byte
//  Rev     : 1.0  initial release
// ============================================================================
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    // The current byte drops into its lane so the full word is visible in the
    // same cycle as the last byte, with no extra pipeline stage.
    word_o = shift_q;
    word_o[{cnt_q, 3'b000} +: 8] = data_i;
    word_valid_o = en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (en_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_valid_o ? '0 : word_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : imem_loader
//  Purpose : Loads a program image from a byte stream into instruction memory
//            and holds the core in reset until the image is complete.
//            Stream: 4-byte LE word count N, then N LE words.
//  Ports   : clk_i, rst_i          - clock, synchronous active-high reset
//            byte_valid_i/data_i   - upstream byte stream
//            byte_ready_o          - byte accepted when valid && ready
//            imem_we_o/addr_o/wdata_o - one-cycle instruction-memory write
//            core_rst_o            - core held in reset until DONE
//            done_o / error_o      - terminal status
//            word_count_o          - words written so far
//  Config  : LOADER_CHECKSUM_EN - trailing XOR checksum byte over data bytes.
//  Rev     : 1.0  initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [31:0]   MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic        asm_en;
  logic        word_valid;
  logic [31:0] asm_word;
  logic        all_written;

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready_o = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
`else
  assign byte_ready_o = (state_q == LEN) || (state_q == DATA);
`endif

  assign all_written = (count_q == len_q);
  // Once every word is written the assembler is no longer fed, so a byte
  // arriving in the final DATA cycle cannot start a phantom word.
  assign asm_en = byte_valid_i && byte_ready_o &&
                  ((state_q == LEN) || ((state_q == DATA) && !all_written));

  byte_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (asm_en),
    .data_i       (byte_data_i),
    .word_valid_o (word_valid),
    .word_o       (asm_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      LEN: begin
        if (word_valid) begin
          if (asm_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else if (asm_word > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            len_d   = asm_word[ADDR_W:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (asm_en) csum_d = csum_q ^ byte_data_i;
        if (word_valid && ((count_q + ONE) == len_q)) state_d = CSUM;
`else
        // DONE follows one cycle after the last write strobe.
        if (all_written) state_d = DONE;
`endif
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = asm_word;
          count_d = count_q + ONE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (byte_valid_i) state_d = (byte_data_i == csum_q) ? DONE : ERR;
      end
`endif
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = LEN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LEN;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign word_count_o = count_q;
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERR);
  assign core_rst_o   = (state_q != DONE);

endmodule
`default_nettype wire
